demux_sched_1_8: RTL and testbench

Sequencing controller for a 1:8 demultiplexed datapath. It accepts words from a single valid/ready source and delivers each one to exactly one of eight output lanes. Lane choice is either round-robin over enabled lanes or directed by a per-word destination field. Output is registered with per-lane valid/ready handshakes, so the block sits between a shared producer and eight independent consumers and owns the `sel` sequencing of the demux.

---
 rtl/demux_sched_1_8.sv | 100 ++++++++++
 tb/tb_demux_sched_1_8.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_sched_1_8.sv
// 1:8 demultiplexing sequencer: takes words from one valid/ready source and
// hands each to a single output lane, chosen round-robin or by a destination field.
module demux_sched_1_8 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_dest,
  input  logic              in_mode,
  output logic              in_ready,
  input  logic [7:0]        en_mask,
  output logic [7:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [7:0]        out_ready,
  output logic [2:0]        cur_sel,
  output logic              drop_pulse,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] rr_ptr;
  logic [2:0] rr_tgt;
  logic [2:0] tgt;
  logic       drain;
  logic       rr_ok;
  logic       accept;
  logic       drop;
  logic       load;

  assign drain    = (state == HOLD) && out_ready[cur_sel];
  assign rr_ok    = |en_mask;
  assign in_ready = ((state == IDLE) || drain) && (in_mode || rr_ok);
  assign accept   = in_valid && in_ready;

  // Directed words aimed at a disabled lane are still accepted so they can be dropped.
  assign drop = accept && in_mode && !en_mask[in_dest];
  assign load = accept && !drop;
  assign tgt  = in_mode ? in_dest : rr_tgt;

  // First enabled lane strictly after rr_ptr, wrapping 7 -> 0; i=8 revisits rr_ptr itself.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value unassigned and no latch is inferred.
    rr_tgt = rr_ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = rr_ptr + 3'(i);
      if (!found && en_mask[idx]) begin
        rr_tgt = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = HOLD;
    else if (drain)
      state_nxt = IDLE;
  end

  // NOTE: clocked state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 3'd7;
      cur_sel    <= 3'd0;
      out_data   <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop;
      if (load) begin
        out_data <= in_data;
        cur_sel  <= tgt;
      end
      if (load && !in_mode)
        rr_ptr <= rr_tgt;
      if (drop && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Decoded from state so at most one lane is ever valid.
  assign out_valid = (state == HOLD) ? (8'b1 << cur_sel) : 8'h00;

endmodule

// File: tb/tb_demux_sched_1_8.sv
// Self-checking bench for demux_sched_1_8: directed scenarios plus randomized
// traffic compared against a transaction-level lane/drop model.
module tb_demux_sched_1_8;

  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_dest;
  logic              in_mode;
  logic              in_ready;
  logic [7:0]        en_mask;
  logic [7:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_ready;
  logic [2:0]        cur_sel;
  logic              drop_pulse;
  logic [7:0]        drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what lane holds which word, next round-robin start, drop total.
  bit              m_hold;
  int              m_lane;
  logic [DATA_W-1:0] m_data;
  int              m_rr;
  int              m_drops;
  bit              m_pulse;

  int                deliv_lane[$];
  logic [DATA_W-1:0] deliv_data[$];

  demux_sched_1_8 #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .in_mode    (in_mode),
    .in_ready   (in_ready),
    .en_mask    (en_mask),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .cur_sel    (cur_sel),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, need done");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hold  = 1'b0;
    m_lane  = 0;
    m_data  = '0;
    m_rr    = 7;
    m_drops = 0;
    m_pulse = 1'b0;
  endtask

  // Entered just after a rising edge with inputs already driven; compares
  // the DUT to the model mid-cycle, then advances both across one edge.
  task automatic cycle();
    bit              exp_ready;
    logic [7:0]      exp_valid;
    bit              n_hold;
    int              n_lane;
    logic [DATA_W-1:0] n_data;
    int              n_rr;
    int              n_drops;
    bit              n_pulse;
    @(negedge clk);
    exp_ready = (!m_hold || out_ready[m_lane]) && (in_mode || (en_mask != 8'h00));
    exp_valid = m_hold ? (8'h01 << m_lane) : 8'h00;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (m_hold) begin
      check("out_data", 32'(out_data), 32'(m_data));
      check("cur_sel", 32'(cur_sel), 32'(m_lane));
    end
    check("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
    check("drop_cnt", 32'(drop_cnt), (m_drops > 255) ? 32'd255 : 32'(m_drops));
    if ((out_valid & out_ready) != 8'h00) begin
      for (int i = 0; i < 8; i++)
        if (out_valid[i]) deliv_lane.push_back(i);
      deliv_data.push_back(out_data);
    end
    n_hold  = m_hold && !out_ready[m_lane];
    n_lane  = m_lane;
    n_data  = m_data;
    n_rr    = m_rr;
    n_drops = m_drops;
    n_pulse = 1'b0;
    if (in_valid && exp_ready) begin
      if (in_mode) begin
        if (en_mask[in_dest]) begin
          n_hold = 1'b1;
          n_lane = int'(in_dest);
          n_data = in_data;
        end else begin
          n_pulse = 1'b1;
          n_drops = m_drops + 1;
        end
      end else begin
        for (int k = 1; k <= 8; k++) begin
          if (en_mask[(m_rr + k) % 8]) begin
            n_lane = (m_rr + k) % 8;
            break;
          end
        end
        n_hold = 1'b1;
        n_data = in_data;
        n_rr   = n_lane;
      end
    end
    @(posedge clk);
    #1;
    m_hold  = n_hold;
    m_lane  = n_lane;
    m_data  = n_data;
    m_rr    = n_rr;
    m_drops = n_drops;
    m_pulse = n_pulse;
  endtask

  initial begin
    int exp_lanes_a[10];
    int exp_lanes_b[4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dest   = 3'd0;
    in_mode   = 1'b0;
    en_mask   = 8'h00;
    out_ready = 8'h00;
    model_reset();

    #12;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst cur_sel", 32'(cur_sel), 32'h0);
    check("rst drop_pulse", 32'(drop_pulse), 32'h0);
    check("rst drop_cnt", 32'(drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin over all lanes, full throughput.
    exp_lanes_a = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    in_mode   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hD0 + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("rr10 count", 32'(deliv_lane.size()), 32'd10);
    for (int i = 0; i < 10 && i < deliv_lane.size(); i++) begin
      check("rr10 lane", 32'(deliv_lane[i]), 32'(exp_lanes_a[i]));
      check("rr10 data", 32'(deliv_data[i]), 32'(8'hD0 + 8'(i)));
    end

    // Round-robin skipping disabled lanes.
    exp_lanes_b = '{2, 5, 7, 2};
    deliv_lane.delete();
    deliv_data.delete();
    en_mask = 8'b1010_0100;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h40 + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    check("skip count", 32'(deliv_lane.size()), 32'd4);
    for (int i = 0; i < 4 && i < deliv_lane.size(); i++)
      check("skip lane", 32'(deliv_lane[i]), 32'(exp_lanes_b[i]));
    en_mask  = 8'h00;
    in_valid = 1'b1;
    #1;
    check("mask0 in_ready", 32'(in_ready), 32'h0);
    cycle();
    in_valid = 1'b0;

    // Back-pressure on lane 3 with a second word waiting.
    en_mask   = 8'hFF;
    in_mode   = 1'b1;
    in_dest   = 3'd3;
    in_data   = 8'hA5;
    out_ready = 8'hF7;
    in_valid  = 1'b1;
    cycle();
    in_dest = 3'd5;
    in_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      check("bp out_valid", 32'(out_valid), 32'h08);
      check("bp out_data", 32'(out_data), 32'hA5);
      check("bp in_ready", 32'(in_ready), 32'h0);
      cycle();
    end
    out_ready = 8'hFF;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'h1);
    cycle();
    check("bp reload out_valid", 32'(out_valid), 32'h20);
    check("bp reload out_data", 32'(out_data), 32'h5A);
    in_valid = 1'b0;
    cycle();

    // Directed mode with lane 4 disabled.
    en_mask  = 8'hEF;
    in_valid = 1'b1;
    in_dest  = 3'd6;
    in_data  = 8'h66;
    cycle();
    check("dir6 out_valid", 32'(out_valid), 32'h40);
    in_dest = 3'd4;
    in_data = 8'h44;
    cycle();
    check("drop pulse", 32'(drop_pulse), 32'h1);
    check("drop cnt1", 32'(drop_cnt), 32'h1);
    check("drop out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b0;
    cycle();
    check("drop pulse end", 32'(drop_pulse), 32'h0);
    en_mask  = 8'hFF;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    cycle();
    check("rr after drop", 32'(cur_sel), 32'h3);
    in_valid = 1'b0;
    cycle();
    en_mask  = 8'hEF;
    in_mode  = 1'b1;
    in_dest  = 3'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    in_valid = 1'b0;
    check("drop saturate", 32'(drop_cnt), 32'd255);
    cycle();

    // Disabling the held lane does not retract its word.
    deliv_lane.delete();
    deliv_data.delete();
    en_mask   = 8'hFF;
    in_dest   = 3'd1;
    in_data   = 8'hC1;
    out_ready = 8'hFD;
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    en_mask  = 8'hFD;
    cycle();
    cycle();
    out_ready = 8'hFF;
    cycle();
    check("mask clr count", 32'(deliv_lane.size()), 32'd1);
    if (deliv_lane.size() > 0) begin
      check("mask clr lane", 32'(deliv_lane[0]), 32'd1);
      check("mask clr data", 32'(deliv_data[0]), 32'hC1);
    end

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = $urandom_range(0, 1) == 1;
      in_dest   = 3'($urandom_range(0, 7));
      in_data   = 8'($urandom);
      en_mask   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      out_ready = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 8'hFF;
    cycle();

    // Asynchronous reset while holding a word.
    en_mask   = 8'hFF;
    in_mode   = 1'b1;
    in_dest   = 3'd2;
    in_data   = 8'h77;
    out_ready = 8'h00;
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("pre-rst out_valid", 32'(out_valid), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 32'(out_valid), 32'h0);
    check("async rst cur_sel", 32'(cur_sel), 32'h0);
    check("async rst out_data", 32'(out_data), 32'h0);
    check("async rst drop_cnt", 32'(drop_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    in_mode   = 1'b0;
    out_ready = 8'hFF;
    in_data   = 8'h99;
    in_valid  = 1'b1;
    cycle();
    check("post-rst rr lane", 32'(cur_sel), 32'h0);
    check("post-rst out_valid", 32'(out_valid), 32'h01);
    in_valid = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
